// File: rtl/noc_link_pipe.sv
// noc_link_pipe: flow-controlled NoC link pipeline built from chained
// two-entry relay stations. Every stage registers the forward path
// (flit, aux, valid) and the backward stall, so long links can be cut into
// short timing paths while still moving one flit per cycle.
//
// noc_relay_station occupancy:
//   cnt | meaning
//   ----+-----------------------------------------------------------
//    0  | empty, output invalid
//    1  | main holds the head flit, spare free
//    2  | main and spare both hold flits, stall raised to upstream

module noc_relay_station #(
    parameter int W = 33
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] data_in,
    input  logic         valid_in,
    output logic         stall_out,
    output logic [W-1:0] data_out,
    output logic         valid_out,
    input  logic         stall_in
);

    logic [1:0]   cnt_q;
    logic [1:0]   cnt_next;
    logic [W-1:0] main_q;
    logic [W-1:0] main_next;
    logic [W-1:0] spare_q;
    logic [W-1:0] spare_next;
    logic         stall_q;
    logic         push;
    logic         pop;

    // A flit enters only when the upstream saw no stall from us, and leaves
    // only when we hold one and downstream is not stalling.
    assign push = valid_in && !stall_q;
    assign pop  = (cnt_q != 2'd0) && !stall_in;

    // Next occupancy and slot contents; the head flit always sits in main.
    always_comb begin
        cnt_next   = cnt_q;
        main_next  = main_q;
        spare_next = spare_q;
        if (push && pop) begin
            if (cnt_q == 2'd1) begin
                main_next = data_in;
            end else begin
                if (cnt_q == 2'd2) begin
                    main_next = spare_q;
                end
                spare_next = data_in;
            end
        end else if (pop) begin
            cnt_next = cnt_q - 2'd1;
            if (cnt_q == 2'd2) begin
                main_next = spare_q;
            end
        end else if (push && (cnt_q != 2'd2)) begin
            cnt_next = cnt_q + 2'd1;
            if (cnt_q == 2'd0) begin
                main_next = data_in;
            end else begin
                spare_next = data_in;
            end
        end
    end

    // State registers; stall is registered from the next occupancy so the
    // spare slot is free to catch the flit already in flight from upstream.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= 2'd0;
            main_q  <= '0;
            spare_q <= '0;
            stall_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_next;
            main_q  <= main_next;
            spare_q <= spare_next;
            stall_q <= (cnt_next == 2'd2);
        end
    end

    // An upstream that honours stall can never push into a full station.
    a_no_push_when_full : assert property (
        @(posedge clk) disable iff (rst) !(push && (cnt_q == 2'd2))
    );

    assign stall_out = stall_q;
    assign data_out  = main_q;
    assign valid_out = (cnt_q != 2'd0);

endmodule

module noc_link_pipe #(
    parameter int FLIT_WIDTH = 32,
    parameter int AUX_WIDTH  = 1,
    parameter int STAGES     = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [FLIT_WIDTH-1:0] flit_in,
    input  logic                  valid_in,
    input  logic [AUX_WIDTH-1:0]  aux_in,
    output logic                  stall_out,
    output logic [FLIT_WIDTH-1:0] flit_out,
    output logic                  valid_out,
    output logic [AUX_WIDTH-1:0]  aux_out,
    input  logic                  stall_in,
    output logic                  busy
);

    // Flit and aux travel as one word so they can never be separated.
    localparam int DW = FLIT_WIDTH + AUX_WIDTH;

    generate
        if (STAGES == 0) begin : g_bypass
            logic unused_ctl;
            assign unused_ctl = clk ^ rst;

            assign flit_out  = flit_in;
            assign aux_out   = aux_in;
            assign valid_out = valid_in;
            assign stall_out = stall_in;
            assign busy      = 1'b0;
        end else begin : g_pipe
            // link k is the interface in front of station k; link STAGES is
            // the downstream port.
            logic [DW-1:0] link_data  [STAGES+1];
            logic          link_valid [STAGES+1];
            logic          link_stall [STAGES+1];

            assign link_data[0]       = {aux_in, flit_in};
            assign link_valid[0]      = valid_in;
            assign stall_out          = link_stall[0];
            assign link_stall[STAGES] = stall_in;

            for (genvar k = 0; k < STAGES; k++) begin : g_stage
                noc_relay_station #(
                    .W (DW)
                ) u_rs (
                    .clk       (clk),
                    .rst       (rst),
                    .data_in   (link_data[k]),
                    .valid_in  (link_valid[k]),
                    .stall_out (link_stall[k]),
                    .data_out  (link_data[k+1]),
                    .valid_out (link_valid[k+1]),
                    .stall_in  (link_stall[k+1])
                );
            end

            assign {aux_out, flit_out} = link_data[STAGES];
            assign valid_out           = link_valid[STAGES];

            // busy: any station holding a flit, taken straight from registers.
            always_comb begin
                busy = 1'b0;
                for (int k = 1; k <= STAGES; k++) begin
                    busy = busy | link_valid[k];
                end
            end
        end
    endgenerate

endmodule
